// File: rtl/marquee_scroller_if.sv
// Marquee scroller bus: message buffer writes, run control, character ROM loop and display drive.
interface marquee_scroller_if #(
    parameter int DIGITS    = 4,
    parameter int MSG_DEPTH = 32
);
    logic                           wr_en;
    logic [$clog2(MSG_DEPTH)-1:0]   wr_addr;
    logic [7:0]                     wr_data;
    logic [$clog2(MSG_DEPTH):0]     msg_len;
    logic                           start;
    logic                           pause;
    logic                           halt;
    logic [7:0]                     ascii_out;
    logic [15:0]                    seg_in;
    logic [15:0]                    seg_out;
    logic [DIGITS-1:0]              dig_n;
    logic                           wrap;
    logic                           busy;

    modport master (
        output wr_en, wr_addr, wr_data, msg_len, start, pause, halt, seg_in,
        input  ascii_out, seg_out, dig_n, wrap, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, msg_len, start, pause, halt, seg_in,
        output ascii_out, seg_out, dig_n, wrap, busy
    );
endinterface

// File: rtl/marquee_scroller.sv
// 16-segment marquee sequencer: message buffer, digit scan, scroll window and ROM loop.
// Build macro MARQUEE_BLANK_GAP_EN: message scrolls fully off (blank gap) before wrapping.
module marquee_scroller #(
    parameter int DIGITS     = 4,
    parameter int MSG_DEPTH  = 32,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 2500000
) (
    input  logic              clk,
    input  logic              rst,
    marquee_scroller_if.slave bus
);
    localparam int AW  = $clog2(MSG_DEPTH);
    localparam int PW  = $clog2(MSG_DEPTH + DIGITS) + 1;
    localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int SRW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     len_r, pos_r;
    logic [DW-1:0]     digit_r, dig1_r;
    logic [SCW-1:0]    scan_cnt_r;
    logic [SRW-1:0]    scroll_cnt_r;
    logic              v1_r, blank1_r;
    logic [7:0]        ascii_r;
    logic [15:0]       seg_r;
    logic [DIGITS-1:0] dig_n_r;
    logic              wrap_r, busy_r;
    logic [7:0]        mem [MSG_DEPTH];

    logic [PW-1:0]     len_in_s, pmax_s, sum_s, divisor_s;
    logic [AW-1:0]     addr_s;
    logic              start_ok_s, scan_tick_s, scroll_tick_s, blank_s;

    // Length latch candidate, tick decode and character address for the current scan slot
    always_comb begin
        if (bus.msg_len > (AW + 1)'(MSG_DEPTH)) begin
            len_in_s = PW'(MSG_DEPTH);
        end else begin
            len_in_s = PW'(bus.msg_len);
        end
        start_ok_s    = bus.start && (len_in_s != PW'(0));
        scan_tick_s   = (state_r != ST_IDLE) && (scan_cnt_r == SCW'(SCAN_DIV - 1));
        scroll_tick_s = (state_r == ST_RUN) && (scroll_cnt_r == SRW'(SCROLL_DIV - 1));
        sum_s         = pos_r + PW'(digit_r);
        divisor_s     = (len_r == PW'(0)) ? PW'(1) : len_r;
`ifdef MARQUEE_BLANK_GAP_EN
        pmax_s  = len_r + PW'(DIGITS - 1);
        blank_s = (sum_s >= len_r);
        addr_s  = sum_s[AW-1:0];
`else
        pmax_s  = len_r - PW'(1);
        blank_s = 1'b0;
        addr_s  = AW'(sum_s % divisor_s);
`endif
    end

    // Next-state decode; halt outranks pause, pause outranks start
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.halt || bus.pause) state_s = ST_IDLE;
                else if (start_ok_s)       state_s = ST_RUN;
                else                       state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.halt)       state_s = ST_IDLE;
                else if (bus.pause) state_s = ST_HOLD;
                else                state_s = ST_RUN;
            end
            ST_HOLD: begin
                if (bus.halt)       state_s = ST_IDLE;
                else if (bus.pause) state_s = ST_HOLD;
                else if (bus.start) state_s = ST_RUN;
                else                state_s = ST_HOLD;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, dividers, scroll position and scan digit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            len_r        <= PW'(0);
            pos_r        <= PW'(0);
            digit_r      <= DW'(0);
            scan_cnt_r   <= SCW'(0);
            scroll_cnt_r <= SRW'(0);
            wrap_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            wrap_r  <= (state_s != ST_IDLE) && scroll_tick_s && (pos_r == pmax_s);
            if (state_s == ST_IDLE || state_r == ST_IDLE) begin
                // Leaving IDLE latches the length; everything else restarts from zero
                if (state_r == ST_IDLE) len_r <= len_in_s;
                pos_r        <= PW'(0);
                digit_r      <= DW'(0);
                scan_cnt_r   <= SCW'(0);
                scroll_cnt_r <= SRW'(0);
            end else begin
                scan_cnt_r <= scan_tick_s ? SCW'(0) : scan_cnt_r + 1'b1;
                if (scan_tick_s) begin
                    digit_r <= (digit_r == DW'(DIGITS - 1)) ? DW'(0) : digit_r + 1'b1;
                end
                if (state_r == ST_RUN) begin
                    scroll_cnt_r <= scroll_tick_s ? SRW'(0) : scroll_cnt_r + 1'b1;
                end
                if (scroll_tick_s) begin
                    pos_r <= (pos_r == pmax_s) ? PW'(0) : pos_r + 1'b1;
                end
            end
        end
    end

    // Scan pipeline: fetch character on the tick, then register ROM pattern with its digit enable
    always_ff @(posedge clk) begin
        if (rst || state_s == ST_IDLE) begin
            ascii_r  <= 8'h20;
            seg_r    <= 16'hFFFF;
            dig_n_r  <= {DIGITS{1'b1}};
            v1_r     <= 1'b0;
            blank1_r <= 1'b0;
            dig1_r   <= DW'(0);
        end else begin
            v1_r <= scan_tick_s;
            if (scan_tick_s) begin
                ascii_r  <= blank_s ? 8'h20 : mem[addr_s];
                blank1_r <= blank_s;
                dig1_r   <= digit_r;
            end
            if (v1_r) begin
                seg_r   <= blank1_r ? 16'hFFFF : bus.seg_in;
                dig_n_r <= ~(DIGITS'(1'b1) << dig1_r);
            end
        end
    end

    // Message buffer; contents survive reset and halt
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.ascii_out = ascii_r;
    assign bus.seg_out   = seg_r;
    assign bus.dig_n     = dig_n_r;
    assign bus.wrap      = wrap_r;
    assign bus.busy      = busy_r;
endmodule
